player_motion: RTL and testbench

- Drives the blue character's on-screen position (x_blue, y_blue) from button inputs and the 4-bit collision flags.
- Applies horizontal walking, jumping and gravity, and stops motion against blocked sides.
- Sits upstream of the collision detector and the renderer: its position outputs feed the collision check, and the resulting is_Collision returns here as an input, closing the loop.
- Sprite size is 47x41 pixels on a 640x480 screen.

---
 rtl/player_motion.sv | 183 ++++++++++++++++++
 tb/tb_player_motion.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Blue character motion: walking, jumping and gravity with collision stops.
// Optional DOUBLE_JUMP_EN macro enables one extra jump while airborne.
module player_motion #(
  parameter logic [9:0] X_INIT = 10'd100,
  parameter logic [8:0] Y_INIT = 9'd300,
  parameter logic [9:0] X_STEP = 10'd2,
  parameter logic [3:0] JUMP_V = 4'd8,
  parameter logic [3:0] V_MAX  = 4'd8,
  parameter logic [3:0] G_DIV  = 4'd4,
  parameter logic [9:0] X_MAX  = 10'd593,
  parameter logic [8:0] Y_MAX  = 9'd439
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [3:0] is_Collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] state,
  output logic       facing
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    BAD    = 2'd3
  } vstate_t;

  localparam logic [3:0] GC_TOP = G_DIV - 4'd1;

  vstate_t    st;
  logic [3:0] vy;
  logic [3:0] gc;
  logic       jump_pend;
  logic       jump_prev;

  logic [10:0] x_inc;
  logic [9:0]  x_right;
  logic [9:0]  x_left;
  logic [9:0]  y_sum;
  logic [8:0]  y_dn;
  logic [8:0]  y_up;
  logic        gc_wrap;
  logic [3:0]  gc_next;
  logic [3:0]  vy_dec;
  logic [3:0]  vy_inc;
  logic        dj;

  assign state = st;

  // Clamp in wide arithmetic so the edges never wrap around.
  always_comb begin
    x_inc   = {1'b0, x_blue} + {1'b0, X_STEP};
    x_right = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
    x_left  = (x_blue >= X_STEP) ? (x_blue - X_STEP) : 10'd0;
    y_sum   = {1'b0, y_blue} + {6'd0, vy};
    y_dn    = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[8:0];
    y_up    = (y_blue >= {5'd0, vy}) ? (y_blue - {5'd0, vy}) : 9'd0;
    gc_wrap = (gc == GC_TOP);
    gc_next = gc_wrap ? 4'd0 : (gc + 4'd1);
    vy_dec  = gc_wrap ? (vy - 4'd1) : vy;
    vy_inc  = (gc_wrap && vy < V_MAX) ? (vy + 4'd1) : vy;
  end

`ifdef DOUBLE_JUMP_EN
  logic air_jump;
  logic land;

  assign land = (st == FALL)
             && (is_Collision[0] || y_dn == Y_MAX);
  assign dj = (st == RISE || st == FALL)
           && jump_pend && air_jump;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      air_jump <= 1'b1;
    end else if (tick) begin
      if (dj)
        air_jump <= 1'b0;
      else if (land)
        air_jump <= 1'b1;
    end
  end
`else
  assign dj = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_blue    <= X_INIT;
      y_blue    <= Y_INIT;
      st        <= FALL;
      facing    <= 1'b0;
      vy        <= 4'd1;
      gc        <= 4'd0;
      jump_pend <= 1'b0;
      jump_prev <= 1'b0;
    end else begin
      jump_prev <= btn_jump;
      if (btn_jump && !jump_prev)
        jump_pend <= 1'b1;
      else if (tick)
        jump_pend <= 1'b0;

      if (tick) begin
        if (btn_right && !btn_left) begin
          facing <= 1'b0;
          if (!is_Collision[2])
            x_blue <= x_right;
        end else if (btn_left && !btn_right) begin
          facing <= 1'b1;
          if (!is_Collision[3])
            x_blue <= x_left;
        end

        if (dj) begin
          st <= RISE;
          vy <= JUMP_V;
          gc <= 4'd0;
        end else begin
          unique case (st)
            GROUND: begin
              if (jump_pend) begin
                st <= RISE;
                vy <= JUMP_V;
                gc <= 4'd0;
              end else if (!is_Collision[0]
                           && y_blue < Y_MAX) begin
                st <= FALL;
                vy <= 4'd1;
                gc <= 4'd0;
              end
            end
            RISE: begin
              if (is_Collision[1]) begin
                st <= FALL;
                vy <= 4'd1;
                gc <= 4'd0;
              end else begin
                y_blue <= y_up;
                if (vy_dec == 4'd0 || y_up == 9'd0) begin
                  st <= FALL;
                  vy <= 4'd1;
                  gc <= 4'd0;
                end else begin
                  vy <= vy_dec;
                  gc <= gc_next;
                end
              end
            end
            FALL: begin
              if (is_Collision[0]) begin
                st <= GROUND;
                vy <= 4'd0;
                gc <= 4'd0;
              end else begin
                y_blue <= y_dn;
                if (y_dn == Y_MAX) begin
                  st <= GROUND;
                  vy <= 4'd0;
                  gc <= 4'd0;
                end else begin
                  vy <= vy_inc;
                  gc <= gc_next;
                end
              end
            end
            default: begin
              st <= FALL;
              vy <= 4'd1;
              gc <= 4'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: fall, jump, ceiling, clamps, walls.
// Expectations track DOUBLE_JUMP_EN when it is defined.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [3:0] col;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] st;
  logic       f;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DOUBLE_JUMP_EN
  localparam int DJ_A = 407;
  localparam int DJ_B = 399;
  localparam int DJ_C = 391;
`else
  localparam int DJ_A = 400;
  localparam int DJ_B = 393;
  localparam int DJ_C = 386;
`endif

  player_motion dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .is_Collision (col),
    .x_blue       (x),
    .y_blue       (y),
    .state        (st),
    .facing       (f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input logic [3:0] c);
    @(negedge clk);
    col  = c;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    col  = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic jump_pulse();
    @(negedge clk);
    btn_jump = 1'b1;
    @(negedge clk);
    btn_jump = 1'b0;
  endtask

  initial begin
    int fall_exp [5];
    fall_exp = '{301, 302, 303, 304, 306};
    rst_n     = 1'b0;
    tick      = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    col       = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(x), 100);
    chk("rst_y", 32'(y), 300);
    chk("rst_state", 32'(st), 2);
    chk("rst_facing", 32'(f), 0);

    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_no_tick", 32'(y), 300);

    for (int i = 0; i < 5; i++) begin
      do_tick(4'd0);
      chk("fall_y", 32'(y), 32'(fall_exp[i]));
    end
    chk("fall_state", 32'(st), 2);

    do_tick(4'b0001);
    chk("floor_y", 32'(y), 306);
    chk("floor_state", 32'(st), 0);
    do_tick(4'b0001);
    chk("ground_hold", 32'(st), 0);

    jump_pulse();
    do_tick(4'b0001);
    chk("jump_state", 32'(st), 1);
    chk("jump_y", 32'(y), 306);
    do_tick(4'd0);
    chk("rise1_y", 32'(y), 298);
    repeat (30) do_tick(4'd0);
    chk("rise31_y", 32'(y), 163);
    chk("rise31_state", 32'(st), 1);
    do_tick(4'd0);
    chk("apex_y", 32'(y), 162);
    chk("apex_state", 32'(st), 2);

    do_tick(4'b0001);
    chk("land2_state", 32'(st), 0);
    jump_pulse();
    do_tick(4'b0001);
    chk("jump2_state", 32'(st), 1);
    do_tick(4'b0010);
    chk("ceil_state", 32'(st), 2);
    chk("ceil_y", 32'(y), 162);

    repeat (48) do_tick(4'd0);
    chk("fall48_y", 32'(y), 434);
    chk("fall48_state", 32'(st), 2);
    do_tick(4'd0);
    chk("clamp_y", 32'(y), 439);
    chk("clamp_state", 32'(st), 0);
    do_tick(4'd0);
    chk("bottom_hold", 32'(st), 0);

    btn_left = 1'b1;
    do_tick(4'b1000);
    chk("lblk_x", 32'(x), 100);
    chk("lblk_facing", 32'(f), 1);
    btn_left  = 1'b0;
    btn_right = 1'b1;
    do_tick(4'b0100);
    chk("rblk_x", 32'(x), 100);
    chk("rblk_facing", 32'(f), 0);
    do_tick(4'd0);
    chk("right_x", 32'(x), 102);
    repeat (245) do_tick(4'd0);
    chk("right592_x", 32'(x), 592);
    do_tick(4'd0);
    chk("xmax_x", 32'(x), 593);
    do_tick(4'd0);
    chk("xmax_hold", 32'(x), 593);

    btn_left = 1'b1;
    do_tick(4'd0);
    chk("both_x", 32'(x), 593);
    chk("both_facing", 32'(f), 0);
    btn_right = 1'b0;
    repeat (296) do_tick(4'd0);
    chk("left1_x", 32'(x), 1);
    chk("left_facing", 32'(f), 1);
    do_tick(4'd0);
    chk("left0_x", 32'(x), 0);
    do_tick(4'd0);
    chk("nowrap_x", 32'(x), 0);
    btn_left = 1'b0;
    chk("walk_y", 32'(y), 439);

    jump_pulse();
    do_tick(4'd0);
    chk("j3_state", 32'(st), 1);
    repeat (4) do_tick(4'd0);
    chk("j3_rise4_y", 32'(y), 407);
    jump_pulse();
    do_tick(4'd0);
    chk("dj_second", 32'(y), DJ_A);
    do_tick(4'd0);
    chk("dj_after", 32'(y), DJ_B);
    jump_pulse();
    do_tick(4'd0);
    chk("dj_third", 32'(y), DJ_C);
    chk("dj_state", 32'(st), 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_x", 32'(x), 100);
    chk("mrst_y", 32'(y), 300);
    chk("mrst_state", 32'(st), 2);
    chk("mrst_facing", 32'(f), 0);
    rst_n = 1'b1;
    do_tick(4'd0);
    chk("mrst_fall_y", 32'(y), 301);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
